mem_io_responder: RTL and testbench

- Slave end of the CPU byte-wide memory bus (mem_a / mem_wr / mem_dout from the core, mem_din / io_buffer_full back to it).
- Holds the 128 KB unified RAM and decodes the I/O window (mem_a[17:16]==2'b11).
- I/O window contains: UART TX FIFO with the io_buffer_full back-pressure signal, UART RX FIFO, free-running cycle counter and the program-stop latch.
- Sits between the core and the UART/host harness on the FPGA top and in simulation.

---
 rtl/mem_io_responder.sv | 130 +++++++++++++
 tb/tb_mem_io_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Byte-wide memory bus slave: unified RAM plus an I/O window at 0x3xxxx holding
// the UART TX/RX FIFOs, a free-running cycle counter and the program-stop latch.
module mem_io_responder #(
  parameter int RAM_ADDR_BIT = 17,
  parameter int TX_DEPTH_BIT = 3,
  parameter int RX_DEPTH_BIT = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        program_stop
);

  localparam int TXD = 1 << TX_DEPTH_BIT;
  localparam int RXD = 1 << RX_DEPTH_BIT;
  localparam logic [TX_DEPTH_BIT:0] TX_FULL = (TX_DEPTH_BIT+1)'(TXD);
  // Two-entry margin: the core sees the flag one cycle late and may still push once.
  localparam logic [TX_DEPTH_BIT:0] TX_AF   = (TX_DEPTH_BIT+1)'(TXD - 2);
  localparam logic [RX_DEPTH_BIT:0] RX_FULL = (RX_DEPTH_BIT+1)'(RXD);

  logic [7:0] ram [2**RAM_ADDR_BIT];
  logic [RAM_ADDR_BIT-1:0] ram_idx;
  logic        io_sel;
  logic [15:0] io_off;
  logic        unused_hi;

  assign ram_idx   = mem_a[RAM_ADDR_BIT-1:0];
  assign io_sel    = (mem_a[17:16] == 2'b11);
  assign io_off    = mem_a[15:0];
  assign unused_hi = ^mem_a[31:18];

  logic rd_io, wr_tx, wr_stop;
  assign rd_io   = !mem_wr && io_sel;
  assign wr_tx   = mem_wr && io_sel && (io_off == 16'h0000) && (mem_dout != 8'h00);
  assign wr_stop = mem_wr && io_sel && (io_off == 16'h0004);

  logic [31:0] cnt, snap;

  // TX FIFO
  logic [7:0]              tx_mem [TXD];
  logic [TX_DEPTH_BIT-1:0] tx_wr, tx_rd;
  logic [TX_DEPTH_BIT:0]   tx_count, tx_count_nxt;
  logic                    tx_push, tx_pop, tx_full;
  logic [7:0]              tx_wdata;

  assign tx_full  = (tx_count == TX_FULL);
  assign tx_valid = (tx_count != '0);
  assign tx_data  = tx_mem[tx_rd];
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_push  = (wr_tx || wr_stop) && (!tx_full || tx_pop);
  assign tx_wdata = wr_stop ? 8'h00 : mem_dout;

  always_comb begin
    tx_count_nxt = tx_count;
    if (tx_push && !tx_pop)      tx_count_nxt = tx_count + 1'b1;
    else if (!tx_push && tx_pop) tx_count_nxt = tx_count - 1'b1;
  end

  // RX FIFO
  logic [7:0]              rx_mem [RXD];
  logic [RX_DEPTH_BIT-1:0] rx_wr, rx_rd;
  logic [RX_DEPTH_BIT:0]   rx_count;
  logic                    rx_push, rx_pop;

  assign rx_ready = (rx_count != RX_FULL);
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_io && (io_off == 16'h0000) && (rx_count != '0);

  logic [7:0] io_rdata;
  always_comb begin
    io_rdata = 8'h00;
    case (io_off)
      16'h0000: io_rdata = rx_pop ? rx_mem[rx_rd] : 8'h00;
      16'h0004: io_rdata = cnt[7:0];
      16'h0005: io_rdata = snap[15:8];
      16'h0006: io_rdata = snap[23:16];
      16'h0007: io_rdata = snap[31:24];
      default:  io_rdata = 8'h00;
    endcase
  end

  // Storage arrays carry no reset; contents are meaningful only via pointers/counts.
  always_ff @(posedge clk_in) begin
    if (mem_wr && !io_sel) ram[ram_idx] <= mem_dout;
    if (tx_push) tx_mem[tx_wr] <= tx_wdata;
    if (rx_push) rx_mem[rx_wr] <= rx_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_din        <= 8'h00;
      cnt            <= '0;
      snap           <= '0;
      program_stop   <= 1'b0;
      io_buffer_full <= 1'b0;
      tx_wr          <= '0;
      tx_rd          <= '0;
      tx_count       <= '0;
      rx_wr          <= '0;
      rx_rd          <= '0;
      rx_count       <= '0;
    end else begin
      if (!mem_wr) mem_din <= io_sel ? io_rdata : ram[ram_idx];
      cnt <= cnt + 32'd1;
      if (rd_io && io_off == 16'h0004) snap <= cnt;
      if (wr_stop) program_stop <= 1'b1;

      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      tx_count       <= tx_count_nxt;
      io_buffer_full <= (tx_count_nxt >= TX_AF);

      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, TX/RX FIFOs, counter snapshot, stop latch, reset.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        program_stop;

  int tests = 0;
  int fails = 0;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .program_stop(program_stop)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_wr = 1'b1; mem_dout = d;
    cyc();
    mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
  endtask

  task automatic bus_rd(input logic [31:0] a);
    mem_a = a; mem_wr = 1'b0;
    cyc();
    mem_a = 32'h0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    cyc(); cyc();
    tests++; if (mem_din !== 8'h00) begin fails++; $display("FAIL reset_mem_din got %h want 00", mem_din); end
    tests++; if (io_buffer_full !== 1'b0) begin fails++; $display("FAIL reset_ibf got %b want 0", io_buffer_full); end
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL reset_rx_ready got %b want 1", rx_ready); end
    tests++; if (program_stop !== 1'b0) begin fails++; $display("FAIL reset_stop got %b want 0", program_stop); end
    rst_in = 1'b0;
  endtask

  task automatic test_ram();
    bus_wr(32'h00124, 8'h3C);   // stands in for the simulation preload
    bus_wr(32'h00123, 8'hA5);
    bus_rd(32'h00123);
    tests++; if (mem_din !== 8'hA5) begin fails++; $display("FAIL ram_rd_123 got %h want a5", mem_din); end
    bus_rd(32'h00124);
    tests++; if (mem_din !== 8'h3C) begin fails++; $display("FAIL ram_rd_124 got %h want 3c", mem_din); end
  endtask

  task automatic test_tx_basic();
    tx_ready = 1'b0;
    bus_wr(32'h30000, 8'h48);
    bus_wr(32'h30000, 8'h00);
    bus_wr(32'h30000, 8'h69);
    bus_wr(32'h30001, 8'h77);
    tests++; if (dut.tx_count !== 4'd2) begin fails++; $display("FAIL tx_count got %0d want 2", dut.tx_count); end
    tests++; if (tx_data !== 8'h48 || tx_valid !== 1'b1) begin fails++; $display("FAIL tx_head got %h/%b want 48/1", tx_data, tx_valid); end
    tx_ready = 1'b1;
    cyc();
    tests++; if (tx_data !== 8'h69 || tx_valid !== 1'b1) begin fails++; $display("FAIL tx_second got %h/%b want 69/1", tx_data, tx_valid); end
    cyc();
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL tx_drain_valid got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_tx_full();
    tx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      bus_wr(32'h30000, 8'(i));
      if (i == 5) begin
        tests++; if (io_buffer_full !== 1'b0) begin fails++; $display("FAIL ibf_at5 got %b want 0", io_buffer_full); end
      end
    end
    tests++; if (io_buffer_full !== 1'b1) begin fails++; $display("FAIL ibf_at6 got %b want 1", io_buffer_full); end
    for (int i = 7; i <= 9; i++) bus_wr(32'h30000, 8'(i));
    tests++; if (dut.tx_count !== 4'd8) begin fails++; $display("FAIL tx_full_count got %0d want 8", dut.tx_count); end
    tx_ready = 1'b1; cyc(); tx_ready = 1'b0;
    tests++; if (dut.tx_count !== 4'd7 || io_buffer_full !== 1'b1) begin fails++; $display("FAIL ibf_at7 got %0d/%b want 7/1", dut.tx_count, io_buffer_full); end
    tx_ready = 1'b1; cyc(); tx_ready = 1'b0;
    tests++; if (io_buffer_full !== 1'b1) begin fails++; $display("FAIL ibf_at6_pop got %b want 1", io_buffer_full); end
    tx_ready = 1'b1; cyc(); tx_ready = 1'b0;
    tests++; if (dut.tx_count !== 4'd5 || io_buffer_full !== 1'b0) begin fails++; $display("FAIL ibf_at5_pop got %0d/%b want 5/0", dut.tx_count, io_buffer_full); end
    tx_ready = 1'b1;
    for (int i = 4; i <= 8; i++) begin
      tests++; if (tx_data !== 8'(i)) begin fails++; $display("FAIL tx_drain_%0d got %h want %h", i, tx_data, 8'(i)); end
      cyc();
    end
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL tx_ninth_dropped got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_cnt();
    rst_in = 1'b1;
    cyc();
    rst_in = 1'b0;
    repeat (32'h102) cyc();
    bus_rd(32'h30004);
    tests++; if (mem_din !== 8'h02) begin fails++; $display("FAIL cnt_b0 got %h want 02", mem_din); end
    bus_rd(32'h30005);
    tests++; if (mem_din !== 8'h01) begin fails++; $display("FAIL cnt_b1 got %h want 01", mem_din); end
    bus_rd(32'h30006);
    tests++; if (mem_din !== 8'h00) begin fails++; $display("FAIL cnt_b2 got %h want 00", mem_din); end
    bus_rd(32'h30007);
    tests++; if (mem_din !== 8'h00) begin fails++; $display("FAIL cnt_b3 got %h want 00", mem_din); end
    repeat (300) cyc();
    bus_rd(32'h30005);
    tests++; if (mem_din !== 8'h01) begin fails++; $display("FAIL cnt_snap_hold got %h want 01", mem_din); end
  endtask

  task automatic test_rx();
    rx_valid = 1'b1; rx_data = 8'h31; cyc();
    rx_data = 8'h32; cyc();
    rx_valid = 1'b0;
    bus_rd(32'h30000);
    tests++; if (mem_din !== 8'h31) begin fails++; $display("FAIL rx_pop1 got %h want 31", mem_din); end
    bus_rd(32'h30000);
    tests++; if (mem_din !== 8'h32) begin fails++; $display("FAIL rx_pop2 got %h want 32", mem_din); end
    bus_rd(32'h30000);
    tests++; if (mem_din !== 8'h00) begin fails++; $display("FAIL rx_empty got %h want 00", mem_din); end
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin rx_data = 8'h40 + 8'(i); cyc(); end
    rx_data = 8'h99; cyc();
    rx_valid = 1'b0;
    tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL rx_full_ready got %b want 0", rx_ready); end
    bus_rd(32'h30000);
    tests++; if (mem_din !== 8'h40 || rx_ready !== 1'b1) begin fails++; $display("FAIL rx_after_pop got %h/%b want 40/1", mem_din, rx_ready); end
    for (int i = 1; i < 8; i++) begin
      bus_rd(32'h30000);
      tests++; if (mem_din !== 8'h40 + 8'(i)) begin fails++; $display("FAIL rx_drain_%0d got %h want %h", i, mem_din, 8'h40 + 8'(i)); end
    end
    bus_rd(32'h30000);
    tests++; if (mem_din !== 8'h00) begin fails++; $display("FAIL rx_overflow_dropped got %h want 00", mem_din); end
  endtask

  task automatic test_stop_reset();
    tx_ready = 1'b0;
    bus_wr(32'h30004, 8'hAB);
    tests++; if (program_stop !== 1'b1) begin fails++; $display("FAIL stop_set got %b want 1", program_stop); end
    tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin fails++; $display("FAIL stop_tx got %b/%h want 1/00", tx_valid, tx_data); end
    bus_wr(32'h30000, 8'h11);
    bus_wr(32'h30000, 8'h22);
    tests++; if (dut.tx_count !== 4'd3 || program_stop !== 1'b1) begin fails++; $display("FAIL stop_queue got %0d/%b want 3/1", dut.tx_count, program_stop); end
    mem_a = 32'h00123; mem_wr = 1'b0; rst_in = 1'b1;
    cyc();
    tests++; if (mem_din !== 8'h00) begin fails++; $display("FAIL rst_rd_forced got %h want 00", mem_din); end
    tests++; if (tx_valid !== 1'b0 || program_stop !== 1'b0) begin fails++; $display("FAIL rst_clear got %b/%b want 0/0", tx_valid, program_stop); end
    rst_in = 1'b0;
    bus_rd(32'h30004);
    tests++; if (mem_din !== 8'h00) begin fails++; $display("FAIL rst_cnt0 got %h want 00", mem_din); end
    bus_rd(32'h30004);
    tests++; if (mem_din !== 8'h01) begin fails++; $display("FAIL rst_cnt1 got %h want 01", mem_din); end
  endtask

  initial begin
    rst_in = 1'b1; mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    test_reset();
    test_ram();
    test_tx_basic();
    test_tx_full();
    test_cnt();
    test_rx();
    test_stop_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
